// File: rtl/gol_pkg.sv
// Shared types and helpers for the Game-of-Life display path.
// State encoding for frame streamers and a clog2 that never returns zero.
package gol_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Coordinate fields need at least one bit even for 1-wide grids.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gol_scan_counter.sv
// Row-major x/y scan counter for a WIDTH x HEIGHT grid.
// Advances x on enable, wraps to the next row at the end of a row, and wraps the frame at the last cell.
module gol_scan_counter
  import gol_pkg::*;
#(
  parameter  int WIDTH  = 5,
  parameter  int HEIGHT = 5,
  localparam int XW     = clog2_min1(WIDTH),
  localparam int YW     = clog2_min1(HEIGHT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  input  logic          i_clr,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_eol,
  output logic          o_last
);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          w_eol;
  logic          w_last;

  assign w_eol  = (r_x == XW'(WIDTH - 1));
  assign w_last = w_eol && (r_y == YW'(HEIGHT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_en) begin
      if (w_eol) begin
        r_x <= '0;
        r_y <= w_last ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_eol  = w_eol;
  assign o_last = w_last;

endmodule

// File: rtl/gol_frame_streamer.sv
// Captures one grid generation and replays it as a row-major cell stream with row/frame markers.
// Optional live-cell population count is built when GOL_POPCOUNT_EN is defined.
module gol_frame_streamer
  import gol_pkg::*;
#(
  parameter  int WIDTH  = 5,
  parameter  int HEIGHT = 5,
  localparam int XW     = clog2_min1(WIDTH),
  localparam int YW     = clog2_min1(HEIGHT),
  localparam int PW     = $clog2(WIDTH * HEIGHT + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    snap_valid,
  output logic                    snap_ready,
  input  logic [WIDTH*HEIGHT-1:0] grid,
  output logic                    cell_valid,
  input  logic                    cell_ready,
  output logic                    cell_data,
  output logic [XW-1:0]           cell_x,
  output logic [YW-1:0]           cell_y,
  output logic                    cell_eol,
  output logic                    cell_last,
  output logic                    pop_valid,
  output logic [PW-1:0]           pop_count
);

  localparam int IW = clog2_min1(WIDTH * HEIGHT);

  state_t                  r_state;
  logic [WIDTH*HEIGHT-1:0] r_snap;
  logic                    r_valid;

  logic          w_capture;
  logic          w_xfer;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic          w_eol;
  logic          w_last;
  logic [IW-1:0] w_idx;

  assign snap_ready = (r_state == IDLE);
  assign w_capture  = snap_valid && snap_ready;
  assign w_xfer     = r_valid && cell_ready;

  gol_scan_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_scan (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_xfer),
    .i_clr (w_capture),
    .o_x   (w_x),
    .o_y   (w_y),
    .o_eol (w_eol),
    .o_last(w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_snap  <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (snap_valid) begin
            r_snap  <= grid;
            r_state <= STREAM;
            r_valid <= 1'b1;
          end
        end
        STREAM: begin
          if (w_xfer && w_last) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign w_idx      = IW'(w_x) * IW'(HEIGHT) + IW'(w_y);
  assign cell_valid = r_valid;
  assign cell_x     = w_x;
  assign cell_y     = w_y;
  // Markers are qualified by valid so a 1-wide grid does not flag eol while idle.
  assign cell_data  = r_valid && r_snap[w_idx];
  assign cell_eol   = r_valid && w_eol;
  assign cell_last  = r_valid && w_last;

`ifdef GOL_POPCOUNT_EN
  logic [PW-1:0] r_acc;
  logic [PW-1:0] r_pop_count;
  logic          r_pop_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc       <= '0;
      r_pop_count <= '0;
      r_pop_valid <= 1'b0;
    end else begin
      r_pop_valid <= 1'b0;
      if (w_capture) begin
        r_acc <= '0;
      end else if (w_xfer) begin
        r_acc <= r_acc + PW'(cell_data);
        if (w_last) begin
          r_pop_count <= r_acc + PW'(cell_data);
          r_pop_valid <= 1'b1;
        end
      end
    end
  end

  assign pop_valid = r_pop_valid;
  assign pop_count = r_pop_count;
`else
  assign pop_valid = 1'b0;
  assign pop_count = '0;
`endif

endmodule

// File: tb/tb_gol_frame_streamer.sv
// Self-checking bench for gol_frame_streamer (5x5) against a row-major reference model.
// Honors GOL_POPCOUNT_EN to choose the expected population-count behaviour.
module tb_gol_frame_streamer;

  localparam int W = 5;
  localparam int H = 5;
  localparam int N = W * H;

  typedef struct packed {
    logic       v;
    logic [2:0] x;
    logic [2:0] y;
    logic       d;
    logic       eol;
    logic       last;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         snap_valid;
  logic         snap_ready;
  logic [N-1:0] grid;
  logic         cell_valid;
  logic         cell_ready;
  logic         cell_data;
  logic [2:0]   cell_x;
  logic [2:0]   cell_y;
  logic         cell_eol;
  logic         cell_last;
  logic         pop_valid;
  logic [4:0]   pop_count;

  int checks = 0;
  int errors = 0;

  gol_frame_streamer #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk       (clk),
    .reset     (reset),
    .snap_valid(snap_valid),
    .snap_ready(snap_ready),
    .grid      (grid),
    .cell_valid(cell_valid),
    .cell_ready(cell_ready),
    .cell_data (cell_data),
    .cell_x    (cell_x),
    .cell_y    (cell_y),
    .cell_eol  (cell_eol),
    .cell_last (cell_last),
    .pop_valid (pop_valid),
    .pop_count (pop_count)
  );

  always #5 clk = ~clk;

  function automatic beat_t model_beat(input logic [N-1:0] g, input int k);
    beat_t b;
    int x, y;
    x      = k % W;
    y      = k / W;
    b.v    = 1'b1;
    b.x    = 3'(x);
    b.y    = 3'(y);
    b.d    = g[x * H + y];
    b.eol  = (x == W - 1);
    b.last = (k == N - 1);
    return b;
  endfunction

  function automatic beat_t observed();
    beat_t b;
    b = '{cell_valid, cell_x, cell_y, cell_data, cell_eol, cell_last};
    return b;
  endfunction

  // Streams one full frame; DUT must be idle at the current negedge.
  task automatic stream_frame(input logic [N-1:0] g, input int mode, input bit hold,
                              input logic [N-1:0] g_next, input string tag);
    beat_t exp_b, act_b;
    int    k   = 0;
    int    cyc = 0;
    bit    tog = 1'b1;
    logic  exp_pv;
    logic [4:0] exp_pc;
    checks++;
    if (snap_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s snap_ready_before: got %b want 1", tag, snap_ready);
    end
    snap_valid = 1'b1;
    grid       = g;
    cell_ready = 1'b0;
    @(negedge clk);
    snap_valid = hold;
    grid       = hold ? g_next : N'($urandom);
    while (k < N && cyc < 2000) begin
      exp_b = model_beat(g, k);
      act_b = observed();
      checks++;
      if (act_b !== exp_b || snap_ready !== 1'b0 || pop_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s beat%0d: got v%b x%0d y%0d d%b eol%b last%b rdy%b pv%b want v%b x%0d y%0d d%b eol%b last%b rdy0 pv0",
                 tag, k, act_b.v, act_b.x, act_b.y, act_b.d, act_b.eol, act_b.last, snap_ready, pop_valid,
                 exp_b.v, exp_b.x, exp_b.y, exp_b.d, exp_b.eol, exp_b.last);
      end
      case (mode)
        0:       cell_ready = 1'b1;
        1:       begin cell_ready = tog; tog = ~tog; end
        default: cell_ready = 1'($urandom_range(0, 1));
      endcase
      if (!hold) grid = N'($urandom);
      if (cell_ready) k++;
      cyc++;
      @(negedge clk);
    end
    if (k < N) begin
      errors++;
      $display("FAIL %s timeout: got %0d beats want %0d", tag, k, N);
    end
    cell_ready = 1'b0;
`ifdef GOL_POPCOUNT_EN
    exp_pv = 1'b1;
    exp_pc = 5'($countones(g));
`else
    exp_pv = 1'b0;
    exp_pc = 5'd0;
`endif
    checks++;
    if (cell_valid !== 1'b0 || snap_ready !== 1'b1 || pop_valid !== exp_pv || pop_count !== exp_pc) begin
      errors++;
      $display("FAIL %s frame_end: got valid%b rdy%b pv%b pc%0d want valid0 rdy1 pv%b pc%0d",
               tag, cell_valid, snap_ready, pop_valid, pop_count, exp_pv, exp_pc);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    snap_valid = 1'b0;
    cell_ready = 1'b0;
    grid       = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (snap_ready !== 1'b1 || cell_valid !== 1'b0 || cell_x !== 3'd0 || cell_y !== 3'd0 ||
        cell_data !== 1'b0 || cell_eol !== 1'b0 || cell_last !== 1'b0 ||
        pop_valid !== 1'b0 || pop_count !== 5'd0) begin
      errors++;
      $display("FAIL reset_values: got rdy%b v%b x%0d y%0d d%b eol%b last%b pv%b pc%0d want rdy1 v0 x0 y0 d0 eol0 last0 pv0 pc0",
               snap_ready, cell_valid, cell_x, cell_y, cell_data, cell_eol, cell_last, pop_valid, pop_count);
    end
  endtask

  task automatic test_single_cell();
    stream_frame(N'(1), 0, 1'b0, '0, "single_cell");
  endtask

  task automatic test_glider_stall();
    logic [N-1:0] g = '0;
    g[1 * H + 0] = 1'b1;
    g[2 * H + 1] = 1'b1;
    g[0 * H + 2] = 1'b1;
    g[1 * H + 2] = 1'b1;
    g[2 * H + 2] = 1'b1;
    stream_frame(g, 1, 1'b0, '0, "glider");
  endtask

  task automatic test_snap_ignored();
    logic [N-1:0] g1 = N'($urandom);
    logic [N-1:0] g2 = ~g1;
    stream_frame(g1, 2, 1'b1, g2, "held_snap_first");
    stream_frame(g2, 2, 1'b0, '0, "held_snap_second");
  endtask

  task automatic test_reset_mid_frame();
    logic [N-1:0] g = N'($urandom) | N'(1);
    beat_t exp_b, act_b;
    snap_valid = 1'b1;
    grid       = g;
    @(negedge clk);
    snap_valid = 1'b0;
    cell_ready = 1'b1;
    repeat (12) @(negedge clk);
    exp_b = model_beat(g, 12);
    act_b = observed();
    checks++;
    if (act_b !== exp_b) begin
      errors++;
      $display("FAIL mid_frame_beat12: got x%0d y%0d d%b want x%0d y%0d d%b",
               act_b.x, act_b.y, act_b.d, exp_b.x, exp_b.y, exp_b.d);
    end
    reset = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    cell_ready = 1'b0;
    checks++;
    if (cell_valid !== 1'b0 || snap_ready !== 1'b1 || cell_x !== 3'd0 || cell_y !== 3'd0 ||
        pop_valid !== 1'b0 || pop_count !== 5'd0) begin
      errors++;
      $display("FAIL reset_abort: got v%b rdy%b x%0d y%0d pv%b pc%0d want v0 rdy1 x0 y0 pv0 pc0",
               cell_valid, snap_ready, cell_x, cell_y, pop_valid, pop_count);
    end
    stream_frame(g, 0, 1'b0, '0, "after_reset");
  endtask

  task automatic test_all_ones();
    stream_frame('1, 0, 1'b0, '0, "all_ones");
  endtask

  task automatic test_random_frames();
    for (int i = 0; i < 4; i++) begin
      stream_frame(N'($urandom), 2, 1'b0, '0, $sformatf("random%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_single_cell();
    test_glider_stall();
    test_snap_ignored();
    test_reset_mid_frame();
    test_all_ones();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
